cpu_controller: RTL and testbench

- Control unit that sits directly upstream of the data-memory/register-file path.
- Holds the program counter (PC) and instruction register (IR), and fetches 16-bit instructions from a synchronous-read instruction ROM.
- Decodes each instruction and drives the data-memory address/write enable, register-file read/write addresses and write enable, write-back mux select and ALU select.
- One Moore FSM; all outputs are combinational from state and IR only.

---
 rtl/cpu_controller.sv | 151 +++++++++++++++
 tb/tb_cpu_controller.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle control unit for a small load/store datapath.
// Holds PC and IR, fetches 16-bit instructions from a synchronous-read ROM,
// and decodes them into data-memory, register-file and ALU controls.
// Every control output is a Moore function of the FSM state and IR.
module cpu_controller #(
    parameter int         PC_W     = 7,
    parameter logic [2:0] ALU_PASS = 3'd0,
    parameter logic [2:0] ALU_ADD  = 3'd1,
    parameter logic [2:0] ALU_SUB  = 3'd2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     IM_data,
    output logic [PC_W-1:0] PC_addr,
    output logic [15:0]     IR_out,
    output logic [7:0]      D_addr,
    output logic            D_W_en,
    output logic            RF_s,
    output logic            RF_W_en,
    output logic [3:0]      RF_W_addr,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      ALU_s0,
    output logic [3:0]      state_out,
    output logic            halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic [3:0]        opcode;

    assign opcode    = ir[15:12];
    assign PC_addr   = pc;
    assign IR_out    = ir;
    assign state_out = state;

    // State register; reset forces INIT from any state, including mid-LOAD and HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // PC/IR update only in FETCH; PC wraps naturally at 2**PC_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
            ir <= 16'h0000;
        end else if (state == S_FETCH) begin
            pc <= pc + PC_ONE;
            ir <= IM_data;
        end
    end

    // Next-state logic; unused opcodes fall through to NOOP.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    4'h1:    state_nxt = S_STORE;
                    4'h2:    state_nxt = S_LOAD_A;
                    4'h3:    state_nxt = S_ADD;
                    4'h4:    state_nxt = S_SUB;
                    4'h5:    state_nxt = S_HALT;
                    default: state_nxt = S_NOOP;
                endcase
            end
            S_NOOP:   state_nxt = S_FETCH;
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_FETCH;
            S_STORE:  state_nxt = S_FETCH;
            S_ADD:    state_nxt = S_FETCH;
            S_SUB:    state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_INIT;
        endcase
    end

    // Moore outputs: everything idle by default, each state overrides its own fields.
    always_comb begin
        D_addr     = 8'h00;
        D_W_en     = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        RF_W_addr  = 4'h0;
        RF_Ra_addr = 4'h0;
        RF_Rb_addr = 4'h0;
        ALU_s0     = ALU_PASS;
        halted     = 1'b0;
        case (state)
            S_STORE: begin
                D_addr     = ir[11:4];
                RF_Ra_addr = ir[3:0];
                D_W_en     = 1'b1;
            end
            S_LOAD_A: begin
                // Address presented a cycle early to cover the data-memory read latency.
                D_addr = ir[11:4];
                RF_s   = 1'b1;
            end
            S_LOAD_B: begin
                D_addr    = ir[11:4];
                RF_s      = 1'b1;
                RF_W_addr = ir[3:0];
                RF_W_en   = 1'b1;
            end
            S_ADD: begin
                RF_Ra_addr = ir[11:8];
                RF_Rb_addr = ir[7:4];
                RF_W_addr  = ir[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = ALU_ADD;
            end
            S_SUB: begin
                RF_Ra_addr = ir[11:8];
                RF_Rb_addr = ir[7:4];
                RF_W_addr  = ir[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = ALU_SUB;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed testbench for cpu_controller with a synchronous-read ROM model.
module tb_cpu_controller;

    localparam int PC_W = 7;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [15:0]     IM_data = 16'h0000;
    logic [PC_W-1:0] PC_addr;
    logic [15:0]     IR_out;
    logic [7:0]      D_addr;
    logic            D_W_en;
    logic            RF_s;
    logic            RF_W_en;
    logic [3:0]      RF_W_addr;
    logic [3:0]      RF_Ra_addr;
    logic [3:0]      RF_Rb_addr;
    logic [2:0]      ALU_s0;
    logic [3:0]      state_out;
    logic            halted;

    logic [15:0] rom [0:127];

    int n_tests = 0;
    int n_fail  = 0;

    cpu_controller #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .IM_data    (IM_data),
        .PC_addr    (PC_addr),
        .IR_out     (IR_out),
        .D_addr     (D_addr),
        .D_W_en     (D_W_en),
        .RF_s       (RF_s),
        .RF_W_en    (RF_W_en),
        .RF_W_addr  (RF_W_addr),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .state_out  (state_out),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction ROM: data valid one cycle after the address.
    always @(posedge clk) IM_data <= rom[PC_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required < 200000)", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    // Holds reset for two edges and releases it at a falling edge; state is INIT here.
    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({state_out, PC_addr, IR_out} !== {4'd0, 7'd0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_regs: state=%0d pc=%0d ir=%h, required state=0 pc=0 ir=0000",
                     state_out, PC_addr, IR_out);
        end
        n_tests++;
        if ({D_addr, D_W_en, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0, halted} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outs: daddr=%h dwe=%b rfs=%b rfwe=%b wa=%h ra=%h rb=%h alu=%0d halted=%b, required all 0",
                     D_addr, D_W_en, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0, halted);
        end
    endtask

    task automatic test_halt();
        logic [3:0] exp_st [0:2];
        exp_st = '{4'd1, 4'd2, 4'd9};
        clear_rom();
        rom[0] = 16'h5000;
        apply_reset();
        n_tests++;
        if (state_out !== 4'd0) begin
            n_fail++;
            $display("FAIL halt_init: state=%0d, required 0", state_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (state_out !== exp_st[i]) begin
                n_fail++;
                $display("FAIL halt_seq[%0d]: state=%0d, required %0d", i, state_out, exp_st[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            n_tests++;
            if ({PC_addr, halted, D_W_en, RF_W_en, state_out} !== {7'd1, 1'b1, 1'b0, 1'b0, 4'd9}) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: pc=%0d halted=%b dwe=%b rfwe=%b state=%0d, required pc=1 halted=1 dwe=0 rfwe=0 state=9",
                         i, PC_addr, halted, D_W_en, RF_W_en, state_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_program();
        logic [3:0] exp_st [0:16];
        logic [3:0] ld_w [0:1];
        logic [7:0] ld_d [0:1];
        int n_la;
        int n_lb;
        int halt_idx;
        exp_st = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd1, 4'd2, 4'd4, 4'd5,
                   4'd1, 4'd2, 4'd7, 4'd1, 4'd2, 4'd6, 4'd1, 4'd2, 4'd9};
        ld_w = '{4'd1, 4'd2};
        ld_d = '{8'h00, 8'h01};
        n_la = 0;
        n_lb = 0;
        halt_idx = -1;
        clear_rom();
        rom[0] = 16'h2001;
        rom[1] = 16'h2012;
        rom[2] = 16'h3123;
        rom[3] = 16'h1023;
        rom[4] = 16'h5000;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            n_tests++;
            if (state_out !== exp_st[i]) begin
                n_fail++;
                $display("FAIL prog_seq[%0d]: state=%0d, required %0d", i, state_out, exp_st[i]);
            end
            if (halted === 1'b1 && halt_idx < 0) halt_idx = i;
            n_tests++;
            if ((D_W_en & RF_W_en) !== 1'b0) begin
                n_fail++;
                $display("FAIL prog_excl[%0d]: dwe=%b rfwe=%b, required not both high", i, D_W_en, RF_W_en);
            end
            if (state_out == 4'd4 && n_la < 2) begin
                n_tests++;
                if ({RF_W_en, RF_s, D_addr, D_W_en} !== {1'b0, 1'b1, ld_d[n_la], 1'b0}) begin
                    n_fail++;
                    $display("FAIL prog_load_a[%0d]: rfwe=%b rfs=%b daddr=%h dwe=%b, required rfwe=0 rfs=1 daddr=%h dwe=0",
                             n_la, RF_W_en, RF_s, D_addr, D_W_en, ld_d[n_la]);
                end
                n_la++;
            end
            if (state_out == 4'd5 && n_lb < 2) begin
                n_tests++;
                if ({RF_W_en, RF_s, RF_W_addr, D_addr, D_W_en} !== {1'b1, 1'b1, ld_w[n_lb], ld_d[n_lb], 1'b0}) begin
                    n_fail++;
                    $display("FAIL prog_load_b[%0d]: rfwe=%b rfs=%b wa=%h daddr=%h dwe=%b, required rfwe=1 rfs=1 wa=%h daddr=%h dwe=0",
                             n_lb, RF_W_en, RF_s, RF_W_addr, D_addr, D_W_en, ld_w[n_lb], ld_d[n_lb]);
                end
                n_lb++;
            end
            if (state_out == 4'd7) begin
                n_tests++;
                if ({RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en, ALU_s0, RF_s, D_W_en} !==
                    {4'd1, 4'd2, 4'd3, 1'b1, 3'd1, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL prog_add: ra=%h rb=%h wa=%h rfwe=%b alu=%0d rfs=%b dwe=%b, required ra=1 rb=2 wa=3 rfwe=1 alu=1 rfs=0 dwe=0",
                             RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en, ALU_s0, RF_s, D_W_en);
                end
            end
            if (state_out == 4'd6) begin
                n_tests++;
                if ({D_addr, D_W_en, RF_Ra_addr, RF_W_en} !== {8'h02, 1'b1, 4'd3, 1'b0}) begin
                    n_fail++;
                    $display("FAIL prog_store: daddr=%h dwe=%b ra=%h rfwe=%b, required daddr=02 dwe=1 ra=3 rfwe=0",
                             D_addr, D_W_en, RF_Ra_addr, RF_W_en);
                end
            end
        end
        n_tests++;
        if (halt_idx != 16 || n_lb != 2) begin
            n_fail++;
            $display("FAIL prog_latency: halt at %0d cycles after first fetch with %0d load writes, required 16 and 2",
                     halt_idx, n_lb);
        end
    endtask

    task automatic test_sub();
        int n_sub;
        n_sub = 0;
        clear_rom();
        rom[0] = 16'h4213;
        rom[1] = 16'h5000;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ALU_s0 == 3'd2) begin
                n_sub++;
                n_tests++;
                if ({state_out, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en, RF_s} !==
                    {4'd8, 4'd2, 4'd1, 4'd3, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL sub_fields: state=%0d ra=%h rb=%h wa=%h rfwe=%b rfs=%b, required state=8 ra=2 rb=1 wa=3 rfwe=1 rfs=0",
                             state_out, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en, RF_s);
                end
            end
        end
        n_tests++;
        if (n_sub != 1 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_once: sub cycles=%0d halted=%b, required 1 and 1", n_sub, halted);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] exp_st [0:5];
        exp_st = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd9};
        clear_rom();
        rom[0] = 16'hF0FF;
        rom[1] = 16'h5000;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (state_out !== exp_st[i]) begin
                n_fail++;
                $display("FAIL ill_seq[%0d]: state=%0d, required %0d", i, state_out, exp_st[i]);
            end
            if (i == 1) begin
                n_tests++;
                if (IR_out !== 16'hF0FF) begin
                    n_fail++;
                    $display("FAIL ill_ir: ir=%h, required f0ff", IR_out);
                end
            end
            if (i == 2) begin
                n_tests++;
                if ({D_W_en, RF_W_en, RF_s, ALU_s0, D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr} !== 26'd0) begin
                    n_fail++;
                    $display("FAIL ill_noop_outs: dwe=%b rfwe=%b rfs=%b alu=%0d daddr=%h wa=%h ra=%h rb=%h, required all 0",
                             D_W_en, RF_W_en, RF_s, ALU_s0, D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr);
                end
            end
            if (i == 3) begin
                n_tests++;
                if (PC_addr !== 7'd1) begin
                    n_fail++;
                    $display("FAIL ill_next_pc: pc=%0d, required 1", PC_addr);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int n_fetch;
        logic [6:0] exp_pc;
        n_fetch = 0;
        clear_rom();
        apply_reset();
        for (int cyc = 0; cyc < 450 && n_fetch < 130; cyc++) begin
            @(negedge clk);
            if (state_out == 4'd1) begin
                exp_pc = 7'(n_fetch % 128);
                n_tests++;
                if (PC_addr !== exp_pc) begin
                    n_fail++;
                    $display("FAIL wrap_pc[%0d]: pc=%0d, required %0d", n_fetch, PC_addr, exp_pc);
                end
                n_fetch++;
            end
        end
        n_tests++;
        if (n_fetch != 130) begin
            n_fail++;
            $display("FAIL wrap_timeout: fetches=%0d, required 130", n_fetch);
        end
    endtask

    task automatic test_reset_mid_load();
        bit found;
        found = 1'b0;
        clear_rom();
        rom[0] = 16'h2005;
        rom[1] = 16'h5000;
        apply_reset();
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            n_tests++;
            if (RF_W_en !== 1'b0) begin
                n_fail++;
                $display("FAIL rml_pre_we[%0d]: rfwe=%b, required 0", i, RF_W_en);
            end
            if (state_out == 4'd4) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rml_timeout: LOAD_A not reached, state=%0d, required 4", state_out);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({state_out, PC_addr, IR_out, RF_W_en} !== {4'd0, 7'd0, 16'h0000, 1'b0}) begin
                n_fail++;
                $display("FAIL rml_after[%0d]: state=%0d pc=%0d ir=%h rfwe=%b, required state=0 pc=0 ir=0000 rfwe=0",
                         i, state_out, PC_addr, IR_out, RF_W_en);
            end
        end
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_halt();
        test_program();
        test_sub();
        test_illegal();
        test_wrap();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
